adc_record: RTL and testbench

- Record-path capture stage, directly upstream of playback: deserializes the codec ADC bitstream on bclk and writes one 16-bit left-channel sample per LR frame into the shared SRAM.
- Playback later reads that SRAM region back.
- Drives the shared SRAM address/data bus only while record is high; tri-states the bus otherwise, so playback can own it.

---
 rtl/adc_record.sv | 145 ++++++++++++++
 tb/tb_adc_record.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adc_record.sv
// ADC record capture: deserializes the left-channel word from the codec ADC
// stream and writes it to shared SRAM. Define ADC_PEAK_EN to add the peak meter.
module adc_record #(
    parameter int                ADDR_W   = 18,
    parameter int                SAMPLE_W = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 18'h3FFFF
) (
    input  logic                bclk,
    input  logic                rst_n,
    input  logic                record,
    input  logic                adclrc,
    input  logic                adcdat,
    output logic [ADDR_W-1:0]   addr,
    output logic [SAMPLE_W-1:0] data,
    output logic                write,
    output logic                full,
    output logic [ADDR_W-1:0]   length,
    output logic [SAMPLE_W-1:0] peak
);

    localparam int CNT_W = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT_L = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_WAIT_R = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_FULL   = 3'd5;

    logic [2:0]          state;
    logic                record_d;
    logic                lrc_d;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   len_r;
    logic [SAMPLE_W-1:0] shift;
    logic [CNT_W-1:0]    cnt;
    logic                write_reg;
    logic                full_r;

    // Bus is released whenever record is low so playback can own it.
    assign addr   = record ? ptr   : {ADDR_W{1'bz}};
    assign data   = record ? shift : {SAMPLE_W{1'bz}};
    assign write  = write_reg & record;
    assign full   = full_r;
    assign length = len_r;

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            record_d  <= 1'b0;
            lrc_d     <= 1'b1;
            ptr       <= '0;
            len_r     <= '0;
            shift     <= '0;
            cnt       <= '0;
            write_reg <= 1'b0;
            full_r    <= 1'b0;
        end else begin
            record_d  <= record;
            lrc_d     <= adclrc;
            write_reg <= 1'b0;
            if (!record) begin
                // Partial samples and an in-flight WRITE are abandoned; length/full persist.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!record_d) begin
                            ptr    <= '0;
                            len_r  <= '0;
                            full_r <= 1'b0;
                            state  <= S_WAIT_L;
                        end
                    end
                    S_WAIT_L: begin
                        if (!adclrc && lrc_d) begin
                            shift[0] <= adcdat;
                            cnt      <= CNT_W'(1);
                            state    <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (adclrc) begin
                            state <= S_WAIT_L;
                        end else begin
                            shift[cnt] <= adcdat;
                            cnt        <= cnt + CNT_W'(1);
                            if (cnt == LAST_BIT)
                                state <= S_WAIT_R;
                        end
                    end
                    S_WAIT_R: begin
                        if (adclrc) begin
                            write_reg <= 1'b1;
                            state     <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        len_r <= len_r + ADDR_W'(1);
                        if (ptr == MAX_ADDR) begin
                            full_r <= 1'b1;
                            state  <= S_FULL;
                        end else begin
                            ptr   <= ptr + ADDR_W'(1);
                            state <= S_WAIT_L;
                        end
                    end
                    S_FULL:  state <= S_FULL;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef ADC_PEAK_EN
    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] peak_r;

    // Two's-complement magnitude; the most negative code saturates.
    always_comb begin
        mag = shift;
        if (shift[SAMPLE_W-1]) begin
            if (shift[SAMPLE_W-2:0] == '0)
                mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
            else
                mag = ~shift + SAMPLE_W'(1);
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n)
            peak_r <= '0;
        else if (record && !record_d && state == S_IDLE)
            peak_r <= '0;
        else if (record && state == S_WRITE && mag > peak_r)
            peak_r <= mag;
    end

    assign peak = peak_r;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_adc_record.sv
// Directed bench for adc_record: frame capture, bus release, short frames,
// full stop, record drop during WRITE, async reset and the optional peak meter.
module tb_adc_record;

    logic bclk, rst_n, record, adclrc, adcdat;

    // Pulled-up nets: a released bus reads all ones.
    tri1  [17:0] addr1;
    tri1  [15:0] data1;
    wire         write1, full1;
    wire  [17:0] length1;
    wire  [15:0] peak1;

    wire  [17:0] addr2;
    wire  [15:0] data2;
    wire         write2, full2;
    wire  [17:0] length2;
    wire  [15:0] peak2;

    adc_record dut (
        .bclk(bclk), .rst_n(rst_n), .record(record), .adclrc(adclrc), .adcdat(adcdat),
        .addr(addr1), .data(data1), .write(write1), .full(full1), .length(length1), .peak(peak1)
    );

    adc_record #(.MAX_ADDR(18'd3)) dut_small (
        .bclk(bclk), .rst_n(rst_n), .record(record), .adclrc(adclrc), .adcdat(adcdat),
        .addr(addr2), .data(data2), .write(write2), .full(full2), .length(length2), .peak(peak2)
    );

`ifdef ADC_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wr2_cnt = 0;

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    // Sample mid-cycle, after the negedge drive has settled.
    always @(negedge bclk) begin
        #3;
        if (write1 === 1'b1) begin
            wa_q.push_back(addr1);
            wd_q.push_back(data1);
        end
        if (write2 === 1'b1) wr2_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic send_frame(input logic [15:0] w, input int nl, input int nr);
        for (int i = 0; i < nl; i++) begin
            @(negedge bclk);
            adclrc = 1'b0;
            adcdat = w[i];
        end
        for (int i = 0; i < nr; i++) begin
            @(negedge bclk);
            adclrc = 1'b1;
            adcdat = 1'b0;
        end
    endtask

    logic [15:0] pk_vals [6];
    logic [15:0] pk_exp  [3];

    initial begin
        pk_vals = '{16'h0100, 16'hFF00, 16'h8000, 16'h0004, 16'h0005, 16'h0006};
        pk_exp  = '{16'h0100, 16'h0100, 16'h7FFF};
        rst_n = 1'b0; record = 1'b0; adclrc = 1'b1; adcdat = 1'b0;
        repeat (3) @(negedge bclk);
        chk("rst_write", 32'(write1), 32'd0);
        chk("rst_full", 32'(full1), 32'd0);
        chk("rst_length", 32'(length1), 32'd0);
        chk("rst_addr_released", 32'(addr1), 32'h3FFFF);
        chk("rst_peak", 32'(peak1), 32'd0);
        rst_n = 1'b1;

        // Three frames of A5C3
        @(negedge bclk); record = 1'b1;
        repeat (2) @(negedge bclk);
        chk("rec_addr0", 32'(addr1), 32'd0);
        chk("rec_data0", 32'(data1), 32'd0);
        wa_q.delete(); wd_q.delete();
        repeat (3) send_frame(16'hA5C3, 16, 16);
        chk("three_writes", 32'(wa_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            chk("wr_addr", 32'(wa_q[i]), 32'(i));
            chk("wr_data", 32'(wd_q[i]), 32'hA5C3);
        end
        chk("length3", 32'(length1), 32'd3);
        chk("peak_a5c3", 32'(peak1), PEAK_ON ? 32'h5A3D : 32'd0);

        // Bus released while not recording
        @(negedge bclk); record = 1'b0;
        wa_q.delete(); wd_q.delete();
        #1;
        chk("idle_addr_z", 32'(addr1), 32'h3FFFF);
        chk("idle_data_z", 32'(data1), 32'hFFFF);
        send_frame(16'h5555, 16, 16);
        chk("idle_no_write", 32'(wa_q.size()), 32'd0);
        chk("idle_write_low", 32'(write1), 32'd0);
        chk("idle_length_kept", 32'(length1), 32'd3);

        // Restart clears length, writes from address 0
        @(negedge bclk); record = 1'b1;
        @(negedge bclk);
        chk("restart_length0", 32'(length1), 32'd0);
        send_frame(16'h1234, 16, 16);
        chk("restart_writes", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("restart_addr", 32'(wa_q[0]), 32'd0);
            chk("restart_data", 32'(wd_q[0]), 32'h1234);
        end

        // Short frame is discarded
        wa_q.delete(); wd_q.delete();
        send_frame(16'hFFFF, 9, 16);
        chk("short_no_write", 32'(wa_q.size()), 32'd0);
        send_frame(16'h0F0F, 16, 16);
        chk("after_short_writes", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("after_short_addr", 32'(wa_q[0]), 32'd1);
            chk("after_short_data", 32'(wd_q[0]), 32'h0F0F);
        end
        chk("after_short_len", 32'(length1), 32'd2);

        // Fill the small instance, exercise peak on the default one
        @(negedge bclk); record = 1'b0;
        @(negedge bclk); record = 1'b1;
        @(negedge bclk);
        chk("small_len0", 32'(length2), 32'd0);
        wa_q.delete(); wd_q.delete(); wr2_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            send_frame(pk_vals[k], 16, 16);
            if (k < 3) chk("peak_seq", 32'(peak1), PEAK_ON ? 32'(pk_exp[k]) : 32'd0);
            if (k == 2) chk("small_not_full", 32'(full2), 32'd0);
            if (k == 3) chk("small_full", 32'(full2), 32'd1);
        end
        chk("small_writes", 32'(wr2_cnt), 32'd4);
        chk("small_length", 32'(length2), 32'd4);
        chk("small_full_held", 32'(full2), 32'd1);
        chk("small_addr_stop", 32'(addr2), 32'd3);
        chk("big_writes", 32'(wa_q.size()), 32'd6);
        chk("big_length", 32'(length1), 32'd6);
        chk("big_not_full", 32'(full1), 32'd0);

        // Record dropped during the WRITE cycle
        wa_q.delete(); wd_q.delete();
        send_frame(16'h1111, 16, 0);
        @(negedge bclk); adclrc = 1'b1; adcdat = 1'b0;
        @(posedge bclk); #1; record = 1'b0;
        #1;
        chk("drop_write_low", 32'(write1), 32'd0);
        repeat (15) @(negedge bclk);
        chk("drop_no_write", 32'(wa_q.size()), 32'd0);
        chk("drop_length", 32'(length1), 32'd6);

        // Async reset mid-SHIFT
        @(negedge bclk); record = 1'b1;
        repeat (2) @(negedge bclk);
        send_frame(16'h00F0, 16, 16);
        chk("pre_rst_length", 32'(length1), 32'd1);
        chk("pre_rst_addr", 32'(addr1), 32'd1);
        send_frame(16'h0AAA, 6, 0);
        @(posedge bclk); #1; rst_n = 1'b0;
        #1;
        chk("arst_length", 32'(length1), 32'd0);
        chk("arst_addr", 32'(addr1), 32'd0);
        chk("arst_data", 32'(data1), 32'd0);
        chk("arst_write", 32'(write1), 32'd0);
        chk("arst_full", 32'(full1), 32'd0);
        chk("arst_peak", 32'(peak1), 32'd0);
        @(negedge bclk); rst_n = 1'b1;
        repeat (2) @(negedge bclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
